// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: per-pin GPIO controller in front of a pull-up bidirectional pad cell.
// Define GPIO_DEBOUNCE_EN to insert a DB_LEN-cycle stability filter ahead of in_val.
module gpio_pad_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_LEN      = 8,
  parameter int DB_CW       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic out_val,
  input  logic out_en,
  input  logic od_mode,
  input  logic irq_rise_en,
  input  logic irq_fall_en,
  input  logic irq_clr,
  output logic din,
  output logic oen,
  input  logic dout,
  output logic in_val,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic irq
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gpio_pad_ctrl: SYNC_STAGES must be >= 2");
  end
  if ((DB_LEN < 2) || ((2 ** DB_CW) < DB_LEN)) begin : g_bad_db
    $error("gpio_pad_ctrl: DB_LEN must be >= 2 and fit in DB_CW bits");
  end

  logic                   din_q, din_d;
  logic                   oen_q, oen_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   sync_o;
  logic                   in_val_q, in_val_d;
  logic                   in_prev_q;
  logic                   irq_q, irq_d;
  logic                   rise, fall;

  // Open-drain only ever pulls low; a high request releases the pin to the pull-up.
  always_comb begin
    din_d = out_val;
    oen_d = ~out_en;
    if (od_mode) begin
      din_d = 1'b0;
      oen_d = ~(out_en & ~out_val);
    end
  end

  // DOUT floats while we drive, so loop back the registered drive level instead.
  assign sample = oen_q ? dout : din_q;
  assign sync_o = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CW-1:0] cnt_q, cnt_d;

  always_comb begin
    in_val_d = in_val_q;
    cnt_d    = '0;
    if (sync_o != in_val_q) begin
      if (cnt_q == DB_CW'(DB_LEN - 1)) begin
        in_val_d = sync_o;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    in_val_d = sync_o;
  end
`endif

  assign rise  = in_val_q & ~in_prev_q;
  assign fall  = ~in_val_q & in_prev_q;
  // A new edge takes priority over a same-cycle clear so it is never lost.
  assign irq_d = (rise & irq_rise_en) | (fall & irq_fall_en) | (irq_q & ~irq_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q     <= 1'b0;
      oen_q     <= 1'b1;
      sync_q    <= '1;
      in_val_q  <= 1'b1;
      in_prev_q <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      din_q     <= din_d;
      oen_q     <= oen_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sample};
      in_val_q  <= in_val_d;
      in_prev_q <= in_val_q;
      irq_q     <= irq_d;
    end
  end

  assign din        = din_q;
  assign oen        = oen_q;
  assign in_val     = in_val_q;
  assign rise_pulse = rise;
  assign fall_pulse = fall;
  assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed bench for gpio_pad_ctrl with a pull-up pad model.
// The debounce scenario is only exercised when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_pad_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int DB_LEN      = 8;
  localparam int DB_CW       = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC_STAGES + DB_LEN - 1;
`else
  localparam int LAT = SYNC_STAGES;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic out_val, out_en, od_mode;
  logic irq_rise_en, irq_fall_en, irq_clr;
  logic din, oen, in_val, rise_pulse, fall_pulse, irq;
  logic pad_lvl;
  wire  dout;

  int n_checks = 0;
  int n_fail   = 0;

  // Pad model: level seen on DOUT while released; floats while the pad drives.
  assign dout = oen ? pad_lvl : 1'bz;

  gpio_pad_ctrl #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_LEN     (DB_LEN),
    .DB_CW      (DB_CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .out_val    (out_val),
    .out_en     (out_en),
    .od_mode    (od_mode),
    .irq_rise_en(irq_rise_en),
    .irq_fall_en(irq_fall_en),
    .irq_clr    (irq_clr),
    .din        (din),
    .oen        (oen),
    .dout       (dout),
    .in_val     (in_val),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    out_val     = 1'b0;
    out_en      = 1'b0;
    od_mode     = 1'b0;
    irq_rise_en = 1'b0;
    irq_fall_en = 1'b0;
    irq_clr     = 1'b0;
    pad_lvl     = 1'b1;

    // T1 reset
    #12;
    check_eq("rst_oen", oen, 1'b1);
    check_eq("rst_din", din, 1'b0);
    check_eq("rst_in_val", in_val, 1'b1);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_rise", rise_pulse, 1'b0);
    check_eq("rst_fall", fall_pulse, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(LAT + 2);
    check_eq("idle_in_val", in_val, 1'b1);
    check_eq("idle_fall", fall_pulse, 1'b0);

    // T2 push-pull with loopback
    out_en = 1'b1; od_mode = 1'b0; out_val = 1'b0;
    step(1);
    check_eq("pp_din0", din, 1'b0);
    check_eq("pp_oen0", oen, 1'b0);
    step(LAT);
    check_eq("pp_in_val_hold", in_val, 1'b1);
    check_eq("pp_fall_early", fall_pulse, 1'b0);
    step(1);
    check_eq("pp_in_val_fell", in_val, 1'b0);
    check_eq("pp_fall", fall_pulse, 1'b1);
    step(1);
    check_eq("pp_fall_1cyc", fall_pulse, 1'b0);
    check_eq("pp_irq_off", irq, 1'b0);
    out_val = 1'b1;
    step(1);
    check_eq("pp_din1", din, 1'b1);
    check_eq("pp_oen1", oen, 1'b0);
    step(LAT + 1);
    check_eq("pp_in_val_rose", in_val, 1'b1);
    check_eq("pp_rise", rise_pulse, 1'b1);

    // T3 open-drain
    od_mode = 1'b1;
    step(1);
    check_eq("od_hi_oen", oen, 1'b1);
    check_eq("od_hi_din", din, 1'b0);
    step(LAT + 2);
    check_eq("od_hi_in_val", in_val, 1'b1);
    check_eq("od_hi_no_rise", rise_pulse, 1'b0);
    check_eq("od_hi_no_fall", fall_pulse, 1'b0);
    out_val = 1'b0;
    step(1);
    check_eq("od_lo_oen", oen, 1'b0);
    check_eq("od_lo_din", din, 1'b0);
    step(LAT + 1);
    check_eq("od_lo_in_val", in_val, 1'b0);
    check_eq("od_lo_fall", fall_pulse, 1'b1);
    out_val = 1'b1;
    step(1);
    check_eq("od_rel_oen", oen, 1'b1);
    check_eq("od_rel_din", din, 1'b0);
    step(LAT + 1);
    check_eq("od_rel_in_val", in_val, 1'b1);
    check_eq("od_rel_rise", rise_pulse, 1'b1);

    // T4 input edges and sticky irq
    out_en = 1'b0; od_mode = 1'b0; out_val = 1'b0;
    step(1);
    check_eq("in_oen", oen, 1'b1);
    irq_fall_en = 1'b1;
    step(LAT + 2);
    pad_lvl = 1'b0;
    step(LAT);
    check_eq("in_fall_lat_hold", in_val, 1'b1);
    step(1);
    check_eq("in_fall_in_val", in_val, 1'b0);
    check_eq("in_fall_pulse", fall_pulse, 1'b1);
    check_eq("in_irq_not_yet", irq, 1'b0);
    step(1);
    check_eq("in_irq_set", irq, 1'b1);
    check_eq("in_fall_1cyc", fall_pulse, 1'b0);
    pad_lvl = 1'b1;
    step(LAT + 1);
    check_eq("in_rise_pulse", rise_pulse, 1'b1);
    step(1);
    check_eq("in_irq_sticky", irq, 1'b1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check_eq("in_irq_cleared", irq, 1'b0);
    pad_lvl = 1'b0;
    step(LAT + 1);
    check_eq("in_coinc_fall", fall_pulse, 1'b1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check_eq("in_set_wins", irq, 1'b1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    check_eq("in_clr_again", irq, 1'b0);
    irq_fall_en = 1'b0;
    pad_lvl = 1'b1;
    step(LAT + 2);
    check_eq("in_rise_masked", irq, 1'b0);
    pad_lvl = 1'b0;
    step(LAT + 1);
    check_eq("in_fall_masked_pulse", fall_pulse, 1'b1);
    step(1);
    check_eq("in_fall_masked_irq", irq, 1'b0);
    irq_rise_en = 1'b1;
    pad_lvl = 1'b1;
    step(LAT + 1);
    check_eq("in_rise_en_pulse", rise_pulse, 1'b1);
    step(1);
    check_eq("in_rise_en_irq", irq, 1'b1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    irq_rise_en = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
    // T5 debounce: short glitch rejected, long low accepted
    pad_lvl = 1'b0;
    step(5);
    pad_lvl = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_eq("db_glitch_in_val", in_val, 1'b1);
      check_eq("db_glitch_fall", fall_pulse, 1'b0);
    end
    pad_lvl = 1'b0;
    step(LAT);
    check_eq("db_long_hold", in_val, 1'b1);
    step(1);
    check_eq("db_long_in_val", in_val, 1'b0);
    check_eq("db_long_fall", fall_pulse, 1'b1);
    pad_lvl = 1'b1;
    step(LAT + 2);
    check_eq("db_back_high", in_val, 1'b1);
`endif

    // T6 reset while driving low
    out_en = 1'b1; od_mode = 1'b0; out_val = 1'b0;
    step(1);
    check_eq("mid_oen_drive", oen, 1'b0);
    step(LAT + 2);
    check_eq("mid_in_val_low", in_val, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_oen", oen, 1'b1);
    check_eq("mid_rst_din", din, 1'b0);
    check_eq("mid_rst_in_val", in_val, 1'b1);
    check_eq("mid_rst_irq", irq, 1'b0);
    out_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      step(1);
      check_eq("post_rst_in_val", in_val, 1'b1);
      check_eq("post_rst_rise", rise_pulse, 1'b0);
      check_eq("post_rst_fall", fall_pulse, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
